// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin REQ#/GNT# with turnaround and grant timeout; optional parking via PCI_ARB_PARKING_EN.
// Latency: GNT# registered, one edge after REQ# sampled; reset drops GNT# asynchronously.
// Backpressure: a BUSY owner loses GNT# as soon as another master requests; it finishes its current transaction only.
module pci_arbiter #(
   parameter int  NUM_MASTERS = 4,
   parameter int  GNT_TIMEOUT = 16,
   localparam int OWNER_W     = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [NUM_MASTERS-1:0] REQ,
   input  logic                   FRAME,
   input  logic                   IRDY,
   output logic [NUM_MASTERS-1:0] GNT,
   output logic [OWNER_W-1:0]     OWNER,
   output logic                   BUS_BUSY,
   output logic                   TIMEOUT_PULSE
);

   localparam int                     CNT_W     = $clog2(GNT_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(GNT_TIMEOUT - 1);
   localparam logic [OWNER_W-1:0]     OWNER_RST = OWNER_W'(NUM_MASTERS - 1);
   localparam logic [NUM_MASTERS-1:0] ALL_HIGH  = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANTED,
      S_BUSY,
      S_TURN
   } state_t;

   state_t                  r_state;
   logic [NUM_MASTERS-1:0]  r_gnt;
   logic [OWNER_W-1:0]      r_owner;
   logic                    r_busy;
   logic                    r_tpulse;
   logic [CNT_W-1:0]        r_cnt;

   logic [OWNER_W-1:0]      w_win;
   logic [OWNER_W-1:0]      w_idx;
   logic                    w_any_req;
   logic [NUM_MASTERS-1:0]  w_owner_mask;
   logic [NUM_MASTERS-1:0]  w_win_gnt;
   logic                    w_bus_idle;
   logic                    w_owner_req;
   logic                    w_other_req;
`ifdef PCI_ARB_PARKING_EN
   logic                    w_parked;
`endif

   // Search starts just past the last owner, so the previous grantee ranks last.
   always_comb begin
      w_win     = r_owner;
      w_idx     = r_owner;
      w_any_req = 1'b0;
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         w_idx = OWNER_W'((int'(r_owner) + i) % NUM_MASTERS);
         if (!w_any_req && !REQ[w_idx]) begin
            w_win     = w_idx;
            w_any_req = 1'b1;
         end
      end
   end

   assign w_owner_mask = NUM_MASTERS'(1) << r_owner;
   assign w_win_gnt    = ~(NUM_MASTERS'(1) << w_win);
   assign w_bus_idle   = FRAME & IRDY;
   assign w_owner_req  = |(~REQ & w_owner_mask);
   assign w_other_req  = |(~REQ & ~w_owner_mask);
`ifdef PCI_ARB_PARKING_EN
   assign w_parked     = (r_state == S_IDLE) && |(~r_gnt & w_owner_mask);
`endif

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= S_IDLE;
         r_gnt    <= ALL_HIGH;
         r_owner  <= OWNER_RST;
         r_busy   <= 1'b0;
         r_tpulse <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_tpulse <= 1'b0;
         case (r_state)
            S_IDLE: begin
`ifdef PCI_ARB_PARKING_EN
               if (w_parked && !FRAME) begin
                  r_state <= S_BUSY;
                  r_busy  <= 1'b1;
               end else if (w_any_req && w_bus_idle) begin
                  // A different requester first sees the park grant withdrawn for one cycle.
                  if (w_parked && (w_win != r_owner)) begin
                     r_gnt <= ALL_HIGH;
                  end else begin
                     r_owner <= w_win;
                     r_gnt   <= w_win_gnt;
                     r_cnt   <= '0;
                     r_state <= S_GRANTED;
                  end
               end else if (!w_any_req) begin
                  r_gnt <= ~w_owner_mask;
               end else begin
                  r_gnt <= ALL_HIGH;
               end
`else
               if (w_any_req && w_bus_idle) begin
                  r_owner <= w_win;
                  r_gnt   <= w_win_gnt;
                  r_cnt   <= '0;
                  r_state <= S_GRANTED;
               end else begin
                  r_gnt <= ALL_HIGH;
               end
`endif
            end
            S_GRANTED: begin
               if (!FRAME) begin
                  r_state <= S_BUSY;
                  r_busy  <= 1'b1;
               end else if (!w_owner_req) begin
                  r_gnt   <= ALL_HIGH;
                  r_state <= S_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_gnt    <= ALL_HIGH;
                  r_tpulse <= 1'b1;
                  r_state  <= S_IDLE;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_BUSY: begin
               if (w_bus_idle) begin
                  r_busy  <= 1'b0;
                  r_gnt   <= ALL_HIGH;
                  r_state <= S_TURN;
               end else if (w_owner_req && !w_other_req) begin
                  r_gnt <= ~w_owner_mask;
               end else begin
                  r_gnt <= ALL_HIGH;
               end
            end
            S_TURN: begin
               r_gnt   <= ALL_HIGH;
               r_state <= S_IDLE;
            end
            default: begin
               r_gnt   <= ALL_HIGH;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign GNT           = r_gnt;
   assign OWNER         = r_owner;
   assign BUS_BUSY      = r_busy;
   assign TIMEOUT_PULSE = r_tpulse;

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter (4 masters, timeout 16); parking expectations follow PCI_ARB_PARKING_EN.
module tb_pci_arbiter;

   logic       CLK;
   logic       RST;
   logic [3:0] REQ;
   logic       FRAME;
   logic       IRDY;
   logic [3:0] GNT;
   logic [1:0] OWNER;
   logic       BUS_BUSY;
   logic       TIMEOUT_PULSE;

   int         n_cmp;
   int         n_err;
   logic [3:0] exp_gnt;

   pci_arbiter #(
      .NUM_MASTERS(4),
      .GNT_TIMEOUT(16)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .REQ          (REQ),
      .FRAME        (FRAME),
      .IRDY         (IRDY),
      .GNT          (GNT),
      .OWNER        (OWNER),
      .BUS_BUSY     (BUS_BUSY),
      .TIMEOUT_PULSE(TIMEOUT_PULSE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b0;
      #1;
      tick();
      RST = 1'b1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      REQ   = 4'hF;
      FRAME = 1'b1;
      IRDY  = 1'b1;
      RST   = 1'b1;
      #1 RST = 1'b0;
      #2;
      chk("rst_gnt",   32'(GNT),           32'hF);
      chk("rst_owner", 32'(OWNER),         32'h3);
      chk("rst_busy",  32'(BUS_BUSY),      32'h0);
      chk("rst_tpls",  32'(TIMEOUT_PULSE), 32'h0);
      tick();
      tick();
      RST = 1'b1;

      // Single request: grant after one edge, FRAME two cycles later
      REQ = 4'b1110;
      tick();
      chk("t1_gnt",   32'(GNT),   32'hE);
      chk("t1_owner", 32'(OWNER), 32'h0);
      tick();
      FRAME = 1'b0;
      tick();
      chk("t1_busy",  32'(BUS_BUSY), 32'h1);
      chk("t1_hold",  32'(GNT),      32'hE);
      tick();
      chk("t1_hold2", 32'(GNT),      32'hE);
      FRAME = 1'b1;
      REQ   = 4'hF;
      tick();
      chk("t1_turn_gnt",  32'(GNT),      32'hF);
      chk("t1_turn_busy", 32'(BUS_BUSY), 32'h0);
      tick();
      chk("t1_idle_gnt",  32'(GNT),      32'hF);

      // All masters requesting: rotation 0,1,2,3,0
      REQ = 4'b0000;
      do_reset();
      for (int k = 0; k < 5; k++) begin
         exp_gnt = ~(4'b0001 << (k % 4));
         tick();
         chk("rr_gnt",   32'(GNT),   32'(exp_gnt));
         chk("rr_owner", 32'(OWNER), 32'(k % 4));
         FRAME = 1'b0;
         IRDY  = 1'b0;
         tick();
         chk("rr_busy",  32'(BUS_BUSY), 32'h1);
         tick();
         chk("rr_yield", 32'(GNT), 32'hF);
         tick();
         FRAME = 1'b1;
         IRDY  = 1'b1;
         tick();
         chk("rr_turn_gnt",  32'(GNT),      32'hF);
         chk("rr_turn_busy", 32'(BUS_BUSY), 32'h0);
         tick();
         chk("rr_idle_gnt",  32'(GNT),      32'hF);
      end

      // Master 1 never asserts FRAME: 16 granted cycles, then revoke with pulse
      REQ = 4'b1101;
      tick();
      chk("to_gnt",   32'(GNT),   32'hD);
      chk("to_owner", 32'(OWNER), 32'h1);
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 15) begin
            chk("to_last_gnt",  32'(GNT),           32'hD);
            chk("to_last_tpls", 32'(TIMEOUT_PULSE), 32'h0);
         end
      end
      tick();
      chk("to_rev_gnt",   32'(GNT),           32'hF);
      chk("to_rev_tpls",  32'(TIMEOUT_PULSE), 32'h1);
      chk("to_rev_owner", 32'(OWNER),         32'h1);
      REQ = 4'b1100;
      tick();
      chk("to_next_gnt",  32'(GNT),           32'hE);
      chk("to_next_tpls", 32'(TIMEOUT_PULSE), 32'h0);
      REQ = 4'hF;
      tick();
      chk("rel_gnt", 32'(GNT), 32'hF);

      // Master 0 busy, master 2 requests: early GNT release then handover
      REQ = 4'b1110;
      tick();
      chk("pre_gnt", 32'(GNT), 32'hE);
      FRAME = 1'b0;
      tick();
      chk("pre_busy", 32'(BUS_BUSY), 32'h1);
      tick();
      chk("pre_hold", 32'(GNT), 32'hE);
      REQ = 4'b1010;
      tick();
      chk("pre_drop", 32'(GNT), 32'hF);
      FRAME = 1'b1;
      tick();
      chk("pre_turn", 32'(GNT), 32'hF);
      REQ = 4'b1011;
      tick();
      chk("pre_idle", 32'(GNT), 32'hF);
      tick();
      chk("pre_new_gnt",   32'(GNT),   32'hB);
      chk("pre_new_owner", 32'(OWNER), 32'h2);

      // Asynchronous reset while master 3 is busy
      REQ = 4'hF;
      tick();
      REQ = 4'b0111;
      tick();
      chk("ar_gnt",   32'(GNT),   32'h7);
      chk("ar_owner", 32'(OWNER), 32'h3);
      FRAME = 1'b0;
      tick();
      chk("ar_busy", 32'(BUS_BUSY), 32'h1);
      #2 RST = 1'b0;
      #1;
      chk("ar_rst_gnt",   32'(GNT),      32'hF);
      chk("ar_rst_owner", 32'(OWNER),    32'h3);
      chk("ar_rst_busy",  32'(BUS_BUSY), 32'h0);
      tick();
      FRAME = 1'b1;
      IRDY  = 1'b1;
      REQ   = 4'hF;
      RST   = 1'b1;

      // Foreign FRAME activity blocks a grant
      REQ   = 4'b1110;
      FRAME = 1'b0;
      tick();
      chk("fa_block", 32'(GNT), 32'hF);
      FRAME = 1'b1;
      tick();
      chk("fa_grant", 32'(GNT), 32'hE);
      REQ = 4'hF;
      tick();
      chk("fa_rel", 32'(GNT), 32'hF);

      // Master 2 finishes with nobody requesting: parking behaviour
      REQ = 4'b1011;
      tick();
      chk("pk_gnt", 32'(GNT), 32'hB);
      FRAME = 1'b0;
      tick();
      REQ   = 4'hF;
      FRAME = 1'b1;
      tick();
      tick();
      tick();
`ifdef PCI_ARB_PARKING_EN
      chk("pk_parked", 32'(GNT), 32'hB);
`else
      chk("pk_parked", 32'(GNT), 32'hF);
`endif
      REQ = 4'b1110;
      tick();
`ifdef PCI_ARB_PARKING_EN
      chk("pk_gap", 32'(GNT), 32'hF);
`else
      chk("pk_gap", 32'(GNT), 32'hE);
`endif
      tick();
      chk("pk_new_gnt",   32'(GNT),   32'hE);
      chk("pk_new_owner", 32'(OWNER), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
